m_wb_queue: RTL and testbench

Write-back unit on the producer side of the register-file write port. Accepts results from a single-cycle ALU path (port A) and a long-latency path (port B, loads and multiply). Buffers them in a small FIFO and drains one result per cycle onto the register-file write port (w_we, w_wa, w_wd). Also keeps a per-register busy scoreboard, which issue logic uses to stall on RAW and WAW hazards until the pending write has been committed.

---
 rtl/m_wb_queue.sv | 106 ++++++++++
 tb/tb_m_wb_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/m_wb_queue.sv
// Write-back queue: buffers ALU (A) and long-latency (B) results and drains one per cycle to the RF write port.
// Tracks per-register pending writes so issue can stall on RAW/WAW hazards.
module m_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_a_v,
  input  logic [4:0]  w_a_rd,
  input  logic [31:0] w_a_d,
  output logic        w_a_rdy,
  input  logic        w_b_v,
  input  logic [4:0]  w_b_rd,
  input  logic [31:0] w_b_d,
  output logic        w_b_rdy,
  input  logic        w_hold,
  output logic        w_we,
  output logic [4:0]  w_wa,
  output logic [31:0] w_wd,
  input  logic        w_iss_v,
  input  logic [4:0]  w_iss_rd,
  output logic        w_iss_rdy,
  input  logic [4:0]  w_ra1,
  input  logic [4:0]  w_ra2,
  output logic        w_busy1,
  output logic        w_busy2
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t          r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic [31:0]   r_busy;

  logic   w_full;
  logic   w_push_a;
  logic   w_push_b;
  logic   w_store;
  logic   w_pop;
  logic   w_iss_set;
  ent_t   w_in;
  logic [31:0] w_busy_nxt;

  // Full ignores a same-cycle pop so the ready path never depends on w_hold.
  assign w_full    = (r_count == C_FULL);
  assign w_a_rdy   = ~w_full;
  assign w_b_rdy   = ~w_full & ~w_a_v;
  assign w_push_a  = w_a_v & w_a_rdy;
  assign w_push_b  = w_b_v & w_b_rdy;
  assign w_store   = (w_push_a & (w_a_rd != 5'd0)) | (w_push_b & (w_b_rd != 5'd0));
  assign w_pop     = (r_count != '0) & ~w_hold;
  assign w_in      = w_push_a ? ent_t'({w_a_rd, w_a_d}) : ent_t'({w_b_rd, w_b_d});

  assign w_iss_rdy = (w_iss_rd == 5'd0) | ~r_busy[w_iss_rd];
  assign w_iss_set = w_iss_v & w_iss_rdy & (w_iss_rd != 5'd0);
  assign w_busy1   = r_busy[w_ra1] & (w_ra1 != 5'd0);
  assign w_busy2   = r_busy[w_ra2] & (w_ra2 != 5'd0);

  // Commit clears first so a reservation landing on the same edge survives.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_we) w_busy_nxt[w_wa] = 1'b0;
    if (w_iss_set) w_busy_nxt[w_iss_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_busy  <= '0;
      w_we    <= 1'b0;
      w_wa    <= 5'd0;
      w_wd    <= 32'd0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_store) begin
        r_mem[r_tail] <= w_in;
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) begin
        w_we   <= 1'b1;
        w_wa   <= r_mem[r_head].rd;
        w_wd   <= r_mem[r_head].d;
        r_head <= r_head + 1'b1;
      end else begin
        w_we   <= 1'b0;
      end
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_m_wb_queue.sv
// Bench for m_wb_queue: queue-level reference model plus write scoreboard, directed phases then random traffic.
module tb_m_wb_queue;
  localparam int DEPTH = 4;

  logic        w_clk, w_rst;
  logic        w_a_v, w_b_v, w_hold, w_iss_v;
  logic [4:0]  w_a_rd, w_b_rd, w_iss_rd, w_ra1, w_ra2;
  logic [31:0] w_a_d, w_b_d;
  logic        w_a_rdy, w_b_rdy, w_we, w_iss_rdy, w_busy1, w_busy2;
  logic [4:0]  w_wa;
  logic [31:0] w_wd;

  m_wb_queue #(.DEPTH(DEPTH)) dut (
    .w_clk(w_clk), .w_rst(w_rst),
    .w_a_v(w_a_v), .w_a_rd(w_a_rd), .w_a_d(w_a_d), .w_a_rdy(w_a_rdy),
    .w_b_v(w_b_v), .w_b_rd(w_b_rd), .w_b_d(w_b_d), .w_b_rdy(w_b_rdy),
    .w_hold(w_hold), .w_we(w_we), .w_wa(w_wa), .w_wd(w_wd),
    .w_iss_v(w_iss_v), .w_iss_rd(w_iss_rd), .w_iss_rdy(w_iss_rdy),
    .w_ra1(w_ra1), .w_ra2(w_ra2), .w_busy1(w_busy1), .w_busy2(w_busy2)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  int  total = 0;
  int  bad   = 0;
  wr_t mq[$];
  wr_t exp_q[$];
  bit  mbusy [32];
  bit  m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  bit  started = 0;
  bit  acc_a = 0, acc_b = 0;
  bit  full_m, iss_ok;
  wr_t e_m, e_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a list of stored results, a set of reserved registers, one write slot per edge.
  always @(posedge w_clk) begin
    if (w_rst) begin
      mq.delete();
      foreach (mbusy[i]) mbusy[i] = 0;
      m_we = 0; m_wa = 5'd0; m_wd = 32'd0;
      acc_a = 0; acc_b = 0;
      started = 1;
    end else begin
      full_m = (mq.size() == DEPTH);
      acc_a  = w_a_v && !full_m;
      acc_b  = w_b_v && !w_a_v && !full_m;
      iss_ok = w_iss_v && (w_iss_rd != 0) && !mbusy[w_iss_rd];
      if (m_we) mbusy[m_wa] = 0;
      if (iss_ok) mbusy[w_iss_rd] = 1;
      if (mq.size() > 0 && !w_hold) begin
        e_m = mq.pop_front();
        m_we = 1; m_wa = e_m.rd; m_wd = e_m.d;
        exp_q.push_back(e_m);
      end else begin
        m_we = 0;
      end
      if (acc_a && w_a_rd != 0) mq.push_back(wr_t'({w_a_rd, w_a_d}));
      else if (acc_b && w_b_rd != 0) mq.push_back(wr_t'({w_b_rd, w_b_d}));
    end
  end

  // Monitor: every write presented by the DUT must match the next expected commit.
  always @(negedge w_clk) begin
    if (started) begin
      chk("we", 32'(w_we), 32'(m_we));
      chk("wa_hold", 32'(w_wa), 32'(m_wa));
      chk("wd_hold", w_wd, m_wd);
      if (w_we) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_spurious: got wa=%0d with nothing expected at %0t", w_wa, $time);
        end else begin
          e_s = exp_q.pop_front();
          chk("sb_wa", 32'(w_wa), 32'(e_s.rd));
          chk("sb_wd", w_wd, e_s.d);
        end
      end
      chk("a_rdy", 32'(w_a_rdy), 32'(mq.size() != DEPTH));
      chk("b_rdy", 32'(w_b_rdy), 32'((mq.size() != DEPTH) && !w_a_v));
      chk("iss_rdy", 32'(w_iss_rdy), 32'((w_iss_rd == 0) || !mbusy[w_iss_rd]));
      chk("busy1", 32'(w_busy1), 32'(mbusy[w_ra1] && w_ra1 != 0));
      chk("busy2", 32'(w_busy2), 32'(mbusy[w_ra2] && w_ra2 != 0));
    end
  end

  task automatic cyc();
    @(posedge w_clk);
    #1;
  endtask

  task automatic idle();
    w_rst = 0; w_a_v = 0; w_b_v = 0; w_hold = 0; w_iss_v = 0;
    w_a_rd = 0; w_b_rd = 0; w_iss_rd = 0; w_ra1 = 0; w_ra2 = 0;
    w_a_d = 0; w_b_d = 0;
  endtask

  task automatic push_a(input logic [4:0] rd, input logic [31:0] d);
    w_a_v = 1; w_a_rd = rd; w_a_d = d;
    cyc();
    w_a_v = 0;
  endtask

  initial begin
    idle();
    // Reset with garbage inputs
    w_rst = 1; w_a_v = 1; w_a_rd = 5'd3; w_a_d = $urandom; w_b_v = 1; w_b_rd = 5'd9;
    w_iss_v = 1; w_iss_rd = 5'd4; w_hold = 1;
    cyc(); cyc();
    idle();
    chk("rst_we", 32'(w_we), 32'd0);
    chk("rst_wa", 32'(w_wa), 32'd0);
    chk("rst_wd", w_wd, 32'd0);
    chk("rst_a_rdy", 32'(w_a_rdy), 32'd1);
    w_ra1 = 5'd4; w_ra2 = 5'd3;
    #1 chk("rst_busy", 32'(w_busy1 | w_busy2), 32'd0);

    // Single write: visible one cycle after acceptance
    push_a(5'd5, 32'h1234_5678);
    chk("single_we_early", 32'(w_we), 32'd0);
    cyc();
    chk("single_we", 32'(w_we), 32'd1);
    chk("single_wa", 32'(w_wa), 32'd5);
    chk("single_wd", w_wd, 32'h1234_5678);
    cyc();
    chk("single_we_after", 32'(w_we), 32'd0);
    push_a(5'd0, 32'hdead_beef);
    w_b_v = 1; w_b_rd = 5'd0; w_b_d = 32'hbeef_dead;
    cyc();
    w_b_v = 0;
    cyc(); cyc();

    // Arbitration: A wins for three edges, B lands right after
    w_b_v = 1; w_b_rd = 5'd20; w_b_d = 32'hb0b0_0020;
    for (int i = 0; i < 3; i++) begin
      w_a_v = 1; w_a_rd = 5'(10 + i); w_a_d = 32'(32'ha000 + i);
      #1 chk("arb_b_rdy", 32'(w_b_rdy), 32'd0);
      cyc();
    end
    w_a_v = 0;
    #1 chk("arb_b_rdy_free", 32'(w_b_rdy), 32'd1);
    cyc();
    w_b_v = 0;
    repeat (6) cyc();

    // Full and wrap
    for (int r = 0; r < 3; r++) begin
      w_hold = 1;
      for (int i = 0; i < 4; i++) push_a(5'($urandom_range(1, 31)), $urandom);
      w_a_v = 1; w_a_rd = 5'($urandom_range(1, 31)); w_a_d = $urandom;
      #1 chk("full_a_rdy", 32'(w_a_rdy), 32'd0);
      w_hold = 0;
      cyc();
      cyc();
      w_a_v = 0;
      repeat (6) cyc();
    end

    // Scoreboard reservations
    w_iss_v = 1; w_iss_rd = 5'd7;
    cyc();
    w_iss_v = 0; w_ra1 = 5'd7;
    #1 chk("sb_busy7", 32'(w_busy1), 32'd1);
    chk("sb_iss7_refused", 32'(w_iss_rdy), 32'd0);
    push_a(5'd7, 32'h0000_0777);
    cyc();
    chk("sb_we7", 32'(w_we), 32'd1);
    chk("sb_busy7_until_commit", 32'(w_busy1), 32'd1);
    cyc();
    chk("sb_busy7_cleared", 32'(w_busy1), 32'd0);
    w_iss_v = 1; w_iss_rd = 5'd0; w_ra1 = 5'd0;
    cyc();
    w_iss_v = 0;
    chk("sb_x0_busy", 32'(w_busy1), 32'd0);

    // Mid-operation reset
    w_hold = 1;
    w_iss_v = 1; w_iss_rd = 5'd9;  push_a(5'd1, 32'h11);
    w_iss_v = 1; w_iss_rd = 5'd14; push_a(5'd2, 32'h22);
    w_iss_v = 0; push_a(5'd3, 32'h33);
    w_ra1 = 5'd9; w_ra2 = 5'd14;
    #1 chk("mrst_busy_pre", 32'({w_busy1, w_busy2}), 32'd3);
    w_rst = 1;
    cyc();
    w_rst = 0; w_hold = 0;
    chk("mrst_busy", 32'({w_busy1, w_busy2}), 32'd0);
    repeat (5) begin
      cyc();
      chk("mrst_no_we", 32'(w_we), 32'd0);
    end

    // Random traffic
    idle();
    for (int n = 0; n < 3000; n++) begin
      if (!(w_a_v && !acc_a)) begin
        w_a_v = ($urandom_range(0, 2) == 0);
        w_a_rd = 5'($urandom_range(0, 15)); w_a_d = $urandom;
      end
      if (!(w_b_v && !acc_b)) begin
        w_b_v = ($urandom_range(0, 2) == 0);
        w_b_rd = 5'($urandom_range(0, 15)); w_b_d = $urandom;
      end
      w_hold   = ($urandom_range(0, 3) == 0);
      w_iss_v  = ($urandom_range(0, 1) == 0);
      w_iss_rd = 5'($urandom_range(0, 15));
      w_ra1    = 5'($urandom_range(0, 15));
      w_ra2    = 5'($urandom_range(0, 15));
      w_rst    = ($urandom_range(0, 499) == 0);
      cyc();
    end

    idle();
    repeat (10) cyc();
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
